// File: rtl/framebuffer_pkg.sv
// Shared constants and types for the framebuffer write path.
// Also holds the helper that picks one 2-bit pixel out of a received byte.
package framebuffer_pkg;
   localparam int FB_ADDR_W          = 19;
   localparam int FB_NUM_PIXELS      = 307200;
   localparam int SPRAM_MIN_LOAD_GAP = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } loaderState_t;

   // Pixel 0 is the most significant pair because SPI delivers MSB first.
   function automatic logic [1:0] pixel_sel(input logic [7:0] b, input logic [1:0] idx);
      case (idx)
         2'd0:    return b[7:6];
         2'd1:    return b[5:4];
         2'd2:    return b[3:2];
         2'd3:    return b[1:0];
         default: return 2'd0;
      endcase
   endfunction
endpackage

// File: rtl/spi_pixel_loader_if.sv
// SPI pins plus the controller-facing write strobe bus of the pixel loader.
interface spi_pixel_loader_if;
   import framebuffer_pkg::*;

   logic                 sck;
   logic                 sdi;
   logic                 csN;
   logic [FB_ADDR_W-1:0] addressWrite;
   logic [1:0]           writeData;
   logic                 load;
   logic                 frameDone;
   logic                 overflow;

   modport master (
      input  sck, sdi, csN,
      output addressWrite, writeData, load, frameDone, overflow
   );

   modport slave (
      output sck, sdi, csN,
      input  addressWrite, writeData, load, frameDone, overflow
   );
endinterface

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises the pins into mainClk and assembles bytes.
// csFall is a registered pulse marking the start of a new frame.
module spi_byte_rx (
   input  logic       mainClk,
   input  logic       nreset,
   input  logic       sck,
   input  logic       sdi,
   input  logic       csN,
   output logic       byteValid,
   output logic [7:0] byteData,
   output logic       csFall
);
   logic [1:0] sck_sync_r;
   logic [1:0] sdi_sync_r;
   logic [1:0] cs_sync_r;
   logic       sck_d_r;
   logic       cs_d_r;
   logic [6:0] shift_r;
   logic [2:0] bit_cnt_r;
   logic [7:0] byte_r;
   logic       valid_r;
   logic       cs_fall_r;
   logic       sck_rise_s;
   logic       cs_rise_s;
   logic       cs_fall_s;

   assign sck_rise_s = sck_sync_r[1] & ~sck_d_r;
   assign cs_rise_s  = cs_sync_r[1] & ~cs_d_r;
   assign cs_fall_s  = ~cs_sync_r[1] & cs_d_r;

   // Synchronisers, edge history, shift register and bit counter; chip select idles high.
   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         sck_sync_r <= 2'b00;
         sdi_sync_r <= 2'b00;
         cs_sync_r  <= 2'b11;
         sck_d_r    <= 1'b0;
         cs_d_r     <= 1'b1;
         shift_r    <= 7'd0;
         bit_cnt_r  <= 3'd0;
         byte_r     <= 8'd0;
         valid_r    <= 1'b0;
         cs_fall_r  <= 1'b0;
      end else begin
         sck_sync_r <= {sck_sync_r[0], sck};
         sdi_sync_r <= {sdi_sync_r[0], sdi};
         cs_sync_r  <= {cs_sync_r[0], csN};
         sck_d_r    <= sck_sync_r[1];
         cs_d_r     <= cs_sync_r[1];
         cs_fall_r  <= cs_fall_s;
         valid_r    <= 1'b0;
         if (cs_rise_s) begin
            bit_cnt_r <= 3'd0;
         end else if (sck_rise_s && !cs_sync_r[1]) begin
            shift_r   <= {shift_r[5:0], sdi_sync_r[1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
               byte_r  <= {shift_r, sdi_sync_r[1]};
               valid_r <= 1'b1;
            end
         end
      end
   end

   assign byteValid = valid_r;
   assign byteData  = byte_r;
   assign csFall    = cs_fall_r;
endmodule

// File: rtl/spi_pixel_loader.sv
// Unpacks SPI bytes into 2-bit pixels and issues paced load strobes with a
// sequential, frame-wrapping address to the framebuffer SPRAM controller.
module spi_pixel_loader
   import framebuffer_pkg::*;
#(
   parameter int NUM_PIXELS = FB_NUM_PIXELS,
   parameter int LOAD_GAP   = SPRAM_MIN_LOAD_GAP,
   parameter int FIFO_DEPTH = 2
) (
   input logic                mainClk,
   input logic                nreset,
   spi_pixel_loader_if.master bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int GAP_W = $clog2(LOAD_GAP);
   localparam logic [FB_ADDR_W-1:0] LAST_PIX = FB_ADDR_W'(NUM_PIXELS - 1);

   logic                 byte_valid_s;
   logic [7:0]           rx_byte_s;
   logic                 cs_fall_s;
   logic [7:0]           fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 empty_s, full_s, push_s, pop_s;
   loaderState_t         state_r, state_nx;
   logic [GAP_W-1:0]     gap_r, gap_nx;
   logic [1:0]           idx_r, idx_nx;
   logic [7:0]           byte_r, byte_nx;
   logic                 issue_s, restart_s;
   logic                 restart_pending_r;
   logic [FB_ADDR_W-1:0] pix_cnt_r;
   logic [FB_ADDR_W-1:0] addr_r;
   logic [1:0]           data_r;
   logic                 load_r, frame_done_r, overflow_r;

   spi_byte_rx u_rx (
      .mainClk   (mainClk),
      .nreset    (nreset),
      .sck       (bus.sck),
      .sdi       (bus.sdi),
      .csN       (bus.csN),
      .byteValid (byte_valid_s),
      .byteData  (rx_byte_s),
      .csFall    (cs_fall_s)
   );

   assign empty_s = (cnt_r == CNT_W'(0));
   assign full_s  = (cnt_r == CNT_W'(FIFO_DEPTH));
   assign push_s  = byte_valid_s && (!full_s || pop_s);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   // Unpacker next-state: restart is only honoured once the pipeline has fully drained.
   always_comb begin
      state_nx  = state_r;
      gap_nx    = gap_r;
      idx_nx    = idx_r;
      byte_nx   = byte_r;
      pop_s     = 1'b0;
      issue_s   = 1'b0;
      restart_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (restart_pending_r && empty_s) begin
               restart_s = 1'b1;
            end else if (!empty_s) begin
               pop_s    = 1'b1;
               byte_nx  = fifo_mem_r[rd_ptr_r];
               idx_nx   = 2'd0;
               issue_s  = 1'b1;
               state_nx = ISSUE;
            end else begin
               state_nx = IDLE;
            end
         end
         ISSUE: begin
            gap_nx   = GAP_W'(LOAD_GAP - 2);
            state_nx = GAP;
         end
         GAP: begin
            if (gap_r == GAP_W'(0)) begin
               if (idx_r == 2'd3) begin
                  state_nx = IDLE;
               end else begin
                  idx_nx   = idx_r + 2'd1;
                  issue_s  = 1'b1;
                  state_nx = ISSUE;
               end
            end else begin
               gap_nx = gap_r - GAP_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Byte FIFO storage, pointers and sticky overflow.
   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= 8'd0;
         wr_ptr_r   <= PTR_W'(0);
         rd_ptr_r   <= PTR_W'(0);
         cnt_r      <= CNT_W'(0);
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rx_byte_s;
            wr_ptr_r             <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CNT_W'(1);
            2'b01:   cnt_r <= cnt_r - CNT_W'(1);
            default: cnt_r <= cnt_r;
         endcase
         if (byte_valid_s && !push_s) overflow_r <= 1'b1;
      end
   end

   // FSM state, pixel counter, restart flag and registered strobe outputs.
   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         state_r           <= IDLE;
         gap_r             <= GAP_W'(0);
         idx_r             <= 2'd0;
         byte_r            <= 8'd0;
         restart_pending_r <= 1'b0;
         pix_cnt_r         <= FB_ADDR_W'(0);
         addr_r            <= FB_ADDR_W'(0);
         data_r            <= 2'd0;
         load_r            <= 1'b0;
         frame_done_r      <= 1'b0;
      end else begin
         state_r      <= state_nx;
         gap_r        <= gap_nx;
         idx_r        <= idx_nx;
         byte_r       <= byte_nx;
         load_r       <= issue_s;
         frame_done_r <= issue_s && (pix_cnt_r == LAST_PIX);
         if (cs_fall_s) restart_pending_r <= 1'b1;
         else if (restart_s) restart_pending_r <= 1'b0;
         if (restart_s) begin
            pix_cnt_r <= FB_ADDR_W'(0);
         end else if (issue_s) begin
            pix_cnt_r <= (pix_cnt_r == LAST_PIX) ? FB_ADDR_W'(0) : pix_cnt_r + FB_ADDR_W'(1);
         end
         if (issue_s) begin
            addr_r <= pix_cnt_r;
            data_r <= pixel_sel(byte_nx, idx_nx);
         end
      end
   end

   assign bus.addressWrite = addr_r;
   assign bus.writeData    = data_r;
   assign bus.load         = load_r;
   assign bus.frameDone    = frame_done_r;
   assign bus.overflow     = overflow_r;
endmodule
